// File: rtl/trace_counter_types.sv
// Shared types and constants for the trace event performance-counter bank.
package trace_counter_types;

    // Width of cva5_trace_events_t; flattened bit 0 = br_is_call, bit 32 = early_branch_correction.
    localparam int unsigned NUM_TRACE_EVENTS = 33;

    localparam int unsigned CTRL_ADDR = 0;
    localparam int unsigned OVF_ADDR  = 1;
    localparam int unsigned SEL_BASE  = 2;
    localparam int unsigned CNT_BASE  = 16;

    localparam logic [5:0] SEL_CYCLES = 6'd63;
    localparam logic [5:0] SEL_NONE   = 6'd33;

    typedef struct packed {
        logic ovf_irq_en;
        logic clear;
        logic enable;
    } perf_ctrl_t;

endpackage

// File: rtl/trace_event_counter_slice.sv
// One programmable counter: event select register, event mux, 32-bit counter and
// overflow detection with clear-all > register write > increment priority.
module trace_event_counter_slice
    import trace_counter_types::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic                        clear_all,
    input  logic                        sel_we,
    input  logic                        cnt_we,
    input  logic [31:0]                 wdata,
    input  logic [NUM_TRACE_EVENTS-1:0] event_vec,
    output logic [5:0]                  sel,
    output logic [31:0]                 cnt,
    output logic                        ovf_set
);

    logic [5:0]  sel_q;
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic [63:0] sel_space;
    logic        inc;

    // Full 6-bit select space: 63 is always-on, 33..62 are permanently zero.
    assign sel_space = {1'b1, {(63 - NUM_TRACE_EVENTS){1'b0}}, event_vec};
    assign inc       = enable & sel_space[sel_q];

    always_comb begin
        cnt_d   = cnt_q;
        ovf_set = 1'b0;
        if (clear_all) begin
            cnt_d = '0;
        end else if (cnt_we) begin
            cnt_d = wdata;
        end else if (inc) begin
            cnt_d   = cnt_q + 32'd1;
            ovf_set = &cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= SEL_NONE;
            cnt_q <= '0;
        end else begin
            if (sel_we) begin
                sel_q <= wdata[5:0];
            end
            cnt_q <= cnt_d;
        end
    end

    assign sel = sel_q;
    assign cnt = cnt_q;

endmodule

// File: rtl/trace_event_counters.sv
// Programmable performance-counter bank fed by the core trace event vector, with a
// single-cycle register port for read/write/clear and a registered overflow interrupt.
module trace_event_counters
    import trace_counter_types::*;
#(
    parameter int unsigned NUM_COUNTERS = 8,
    parameter int unsigned EVENT_PIPE   = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_TRACE_EVENTS-1:0] events,
    input  logic                        cfg_valid,
    input  logic                        cfg_write,
    input  logic [4:0]                  cfg_addr,
    input  logic [31:0]                 cfg_wdata,
    output logic                        rd_valid,
    output logic [31:0]                 rd_data,
    output logic                        overflow_irq
);

    logic                        wr_req;
    logic                        rd_req;
    logic [31:0]                 addr32;
    logic                        ctrl_we;
    logic                        ovf_we;
    logic                        clear_all;
    perf_ctrl_t                  ctrl_q;
    logic [NUM_COUNTERS-1:0]     ovf_q;
    logic [NUM_COUNTERS-1:0]     ovf_d;
    logic [NUM_COUNTERS-1:0]     ovf_set;
    logic [NUM_COUNTERS-1:0]     sel_we;
    logic [NUM_COUNTERS-1:0]     cnt_we;
    logic [5:0]                  sel_arr [NUM_COUNTERS];
    logic [31:0]                 cnt_arr [NUM_COUNTERS];
    logic [NUM_TRACE_EVENTS-1:0] event_vec;
    logic [31:0]                 rd_mux;
    logic                        rd_valid_q;
    logic [31:0]                 rd_data_q;
    logic                        irq_q;

    assign wr_req    = cfg_valid & cfg_write;
    assign rd_req    = cfg_valid & ~cfg_write;
    assign addr32    = 32'(cfg_addr);
    assign ctrl_we   = wr_req && (addr32 == CTRL_ADDR);
    assign ovf_we    = wr_req && (addr32 == OVF_ADDR);
    assign clear_all = ctrl_we & cfg_wdata[1];

    if (EVENT_PIPE != 0) begin : g_pipe
        logic [NUM_TRACE_EVENTS-1:0] events_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                events_q <= '0;
            end else begin
                events_q <= events;
            end
        end
        assign event_vec = events_q;
    end else begin : g_nopipe
        assign event_vec = events;
    end

    for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_slice
        // SEL decode yields to CNT when a 16-counter bank makes the ranges overlap.
        assign sel_we[i] = wr_req && (addr32 == SEL_BASE + i) && (addr32 < CNT_BASE);
        assign cnt_we[i] = wr_req && (addr32 == CNT_BASE + i);

        trace_event_counter_slice u_slice (
            .clk       (clk),
            .rst_n     (rst_n),
            .enable    (ctrl_q.enable),
            .clear_all (clear_all),
            .sel_we    (sel_we[i]),
            .cnt_we    (cnt_we[i]),
            .wdata     (cfg_wdata),
            .event_vec (event_vec),
            .sel       (sel_arr[i]),
            .cnt       (cnt_arr[i]),
            .ovf_set   (ovf_set[i])
        );
    end

    // A fresh overflow wins over a write-1-to-clear of the same bit.
    always_comb begin
        ovf_d = ovf_q;
        if (clear_all) begin
            ovf_d = '0;
        end else begin
            if (ovf_we) begin
                ovf_d = ovf_q & ~cfg_wdata[NUM_COUNTERS-1:0];
            end
            ovf_d = ovf_d | ovf_set;
        end
    end

    always_comb begin
        rd_mux = '0;
        if (addr32 == CTRL_ADDR) begin
            rd_mux = 32'(ctrl_q);
        end else if (addr32 == OVF_ADDR) begin
            rd_mux = 32'(ovf_q);
        end else begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                if ((addr32 == SEL_BASE + 32'(i)) && (addr32 < CNT_BASE)) begin
                    rd_mux = {26'd0, sel_arr[i]};
                end
                if (addr32 == CNT_BASE + 32'(i)) begin
                    rd_mux = cnt_arr[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= '0;
            ovf_q      <= '0;
            irq_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            if (ctrl_we) begin
                ctrl_q <= perf_ctrl_t'{
                    ovf_irq_en: cfg_wdata[2],
                    clear:      1'b0,
                    enable:     cfg_wdata[0]
                };
            end
            ovf_q      <= ovf_d;
            irq_q      <= (|ovf_q) & ctrl_q.ovf_irq_en;
            rd_valid_q <= rd_req;
            if (rd_req) begin
                rd_data_q <= rd_mux;
            end
        end
    end

    assign rd_valid     = rd_valid_q;
    assign rd_data      = rd_data_q;
    assign overflow_irq = irq_q;

endmodule

// File: tb/tb_trace_event_counters.sv
// Scoreboard bench for trace_event_counters: reads push expected data, a negedge
// monitor pops and compares on every rd_valid.
module tb_trace_event_counters;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [32:0] events = '0;
    logic        cfg_valid = 1'b0;
    logic        cfg_write = 1'b0;
    logic [4:0]  cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        overflow_irq;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_x;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [12:0] pmask;

    trace_event_counters #(
        .NUM_COUNTERS (8),
        .EVENT_PIPE   (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .events       (events),
        .cfg_valid    (cfg_valid),
        .cfg_write    (cfg_write),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .overflow_irq (overflow_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cfg_valid = 1'b1;
        cfg_write = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        tick();
        cfg_valid = 1'b0;
        cfg_write = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] e);
        exp_t x;
        cfg_valid = 1'b1;
        cfg_write = 1'b0;
        cfg_addr  = a;
        x.addr    = a;
        x.data    = e;
        exp_q.push_back(x);
        tick();
        cfg_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_rd_valid: got rd_data 0x%08h, required no response",
                         rd_data);
            end else begin
                mon_x = exp_q.pop_front();
                chk($sformatf("read_addr%0d", mon_x.addr), rd_data, mon_x.data);
            end
        end
    end

    initial begin
        idle(3);
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_rd_data", rd_data, 32'd0);
        chk("reset_irq", 32'(overflow_irq), 32'd0);
        rst_n = 1'b1;
        idle(1);

        // Reset values across the whole address space, back-to-back reads.
        for (int a = 0; a < 32; a++) begin
            rd(5'(a), (a >= 2 && a <= 9) ? 32'h21 : 32'h0);
        end
        idle(2);

        // Cycle counting: enable held for exactly 100 cycles.
        wr(5'd2, 32'd63);
        wr(5'd0, 32'd1);
        idle(99);
        wr(5'd0, 32'd0);
        rd(5'd16, 32'd100);
        idle(10);
        rd(5'd16, 32'd100);

        // Event 32 pulses around a CNT[1] write in k=5; the k=4 pulse is dropped.
        wr(5'd3, 32'd32);
        wr(5'd0, 32'd1);
        pmask = 13'b0010101110101;
        for (int k = 0; k < 13; k++) begin
            events = pmask[k] ? 33'h1_0000_0000 : 33'h0;
            if (k == 5) begin
                cfg_valid = 1'b1;
                cfg_write = 1'b1;
                cfg_addr  = 5'd17;
                cfg_wdata = 32'h10;
            end
            tick();
            cfg_valid = 1'b0;
            cfg_write = 1'b0;
        end
        events = '0;
        idle(2);
        rd(5'd17, 32'h14);

        // Wrap of CNT[2] after two counts, OVF set and irq one cycle later.
        wr(5'd0, 32'd0);
        wr(5'd18, 32'hFFFF_FFFE);
        wr(5'd4, 32'd63);
        wr(5'd0, 32'd5);
        idle(1);
        wr(5'd0, 32'd4);
        chk("irq_not_yet", 32'(overflow_irq), 32'd0);
        rd(5'd1, 32'h4);
        chk("irq_set", 32'(overflow_irq), 32'd1);
        rd(5'd18, 32'd0);
        wr(5'd1, 32'h4);
        chk("irq_still_set", 32'(overflow_irq), 32'd1);
        rd(5'd1, 32'd0);
        chk("irq_dropped", 32'(overflow_irq), 32'd0);

        // Overflow and W1C on the same edge: the bit stays set.
        wr(5'd18, 32'hFFFF_FFFF);
        wr(5'd0, 32'd5);
        wr(5'd1, 32'h4);
        wr(5'd0, 32'd4);
        rd(5'd1, 32'h4);
        rd(5'd18, 32'd1);

        // Clear-all while counting beats the increment and zeroes OVF.
        wr(5'd0, 32'd1);
        idle(3);
        wr(5'd0, 32'd3);
        rd(5'd16, 32'd0);
        rd(5'd1, 32'd0);
        rd(5'd17, 32'd0);
        rd(5'd0, 32'd1);
        idle(2);

        // Reset asserted mid-count with a read in flight.
        cfg_valid = 1'b1;
        cfg_write = 1'b0;
        cfg_addr  = 5'd16;
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rd_valid", 32'(rd_valid), 32'd0);
        chk("async_rd_data", rd_data, 32'd0);
        chk("async_irq", 32'(overflow_irq), 32'd0);
        cfg_valid = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(3);
        rd(5'd16, 32'd0);
        rd(5'd0, 32'd0);
        rd(5'd2, 32'h21);
        rd(5'd1, 32'd0);
        idle(3);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
